// File: rtl/io_user_buttons_pkg.sv
// Shared constants and types for the user button/switch conditioning path.
// Tick defaults are derived from the 10 kHz debounce enable.
package io_user_buttons_pkg;

   localparam int CE_HZ          = 10000;
   localparam int DEBOUNCE_MS    = 20;
   localparam int LONG_MS        = 1000;
   localparam int DEBOUNCE_TICKS = CE_HZ * DEBOUNCE_MS / 1000;
   localparam int LONG_TICKS     = CE_HZ * LONG_MS / 1000;
   localparam int CNT_WIDTH      = 14;

   typedef enum logic [1:0] {
      ST_LOW      = 2'd0,
      ST_ARM_HIGH = 2'd1,
      ST_HIGH     = 2'd2,
      ST_ARM_LOW  = 2'd3
   } deb_state_t;

endpackage

// File: rtl/io_user_buttons_debounce_channel.sv
// One input bit: 2-FF synchroniser, CE-driven debounce FSM with press/release
// strobes, and an optional long-press detector.
//
// state       | meaning
// ST_LOW      | accepted level 0, counter idle
// ST_ARM_HIGH | accepted level 0, input high, counting CE ticks
// ST_HIGH     | accepted level 1, counter idle
// ST_ARM_LOW  | accepted level 1, input low, counting CE ticks
module io_user_buttons_debounce_channel
   import io_user_buttons_pkg::*;
#(
   parameter int P_DEBOUNCE_TICKS = DEBOUNCE_TICKS,
   parameter int P_LONG_TICKS     = LONG_TICKS,
   parameter int P_CNT_WIDTH      = CNT_WIDTH,
   parameter bit P_LONG_EN        = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel,
   output logic lng
);

   localparam logic [P_CNT_WIDTH-1:0] DEB_LAST  = P_CNT_WIDTH'(P_DEBOUNCE_TICKS - 1);
   localparam logic [P_CNT_WIDTH-1:0] LONG_LAST = P_CNT_WIDTH'(P_LONG_TICKS - 1);

   logic [1:0]             sync;
   logic                   s;
   deb_state_t             state, state_nxt;
   logic [P_CNT_WIDTH-1:0] cnt, cnt_nxt;
   logic                   stable;
   logic                   accept;
   logic                   press_nxt, rel_nxt;

   assign s      = sync[1];
   assign stable = (state == ST_HIGH) || (state == ST_ARM_LOW);
   assign level  = stable;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= '0;
         state <= ST_LOW;
         cnt   <= '0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         sync  <= {sync[0], raw};
         state <= state_nxt;
         cnt   <= cnt_nxt;
         press <= press_nxt;
         rel   <= rel_nxt;
      end
   end

   // Any return of s to the accepted level drops the partial count.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      if (s == stable) begin
         state_nxt = stable ? ST_HIGH : ST_LOW;
         cnt_nxt   = '0;
      end else if (ce) begin
         if (cnt == DEB_LAST) begin
            accept    = 1'b1;
            state_nxt = stable ? ST_LOW : ST_HIGH;
            cnt_nxt   = '0;
         end else begin
            state_nxt = stable ? ST_ARM_LOW : ST_ARM_HIGH;
            cnt_nxt   = cnt + 1'b1;
         end
      end
   end

   always_comb begin
      press_nxt = accept && !stable;
      rel_nxt   = accept && stable;
   end

   if (P_LONG_EN) begin : g_long
      logic [P_CNT_WIDTH-1:0] hcnt;
      logic                   done;
      logic                   lng_q;

      always_ff @(posedge clk) begin
         if (rst || !stable) begin
            hcnt  <= '0;
            done  <= 1'b0;
            lng_q <= 1'b0;
         end else begin
            lng_q <= 1'b0;
            if (ce && !done) begin
               if (hcnt == LONG_LAST) begin
                  lng_q <= 1'b1;
                  done  <= 1'b1;
               end else begin
                  hcnt <= hcnt + 1'b1;
               end
            end
         end
      end

      assign lng = lng_q;
   end else begin : g_no_long
      assign lng = 1'b0;
   end

endmodule

// File: rtl/io_user_buttons.sv
// Conditions board push-buttons and slide switches into clean levels plus
// single-cycle press/release/long-press events on the 100 MHz clock.
module io_user_buttons
   import io_user_buttons_pkg::*;
#(
   parameter int P_BTN_NUM        = 4,
   parameter int P_SW_NUM         = 4,
   parameter int P_DEBOUNCE_TICKS = DEBOUNCE_TICKS,
   parameter int P_LONG_TICKS     = LONG_TICKS,
   parameter int P_CNT_WIDTH      = CNT_WIDTH
) (
   input  logic                 I_CLK_100MHZ,
   input  logic                 I_RST,
   input  logic                 I_CE_10KHZ,
   input  logic [P_BTN_NUM-1:0] I_BTN,
   input  logic [P_SW_NUM-1:0]  I_SW,
   output logic [P_BTN_NUM-1:0] O_BTN_LEVEL,
   output logic [P_BTN_NUM-1:0] O_BTN_PRESS,
   output logic [P_BTN_NUM-1:0] O_BTN_RELEASE,
   output logic [P_BTN_NUM-1:0] O_BTN_LONG,
   output logic [P_SW_NUM-1:0]  O_SW_LEVEL
);

   // Switch channels share the debounce core; their event strobes are dropped.
   logic [P_SW_NUM-1:0] sw_press_unused;
   logic [P_SW_NUM-1:0] sw_rel_unused;
   logic [P_SW_NUM-1:0] sw_long_unused;

   for (genvar i = 0; i < P_BTN_NUM; i++) begin : g_btn
      io_user_buttons_debounce_channel #(
         .P_DEBOUNCE_TICKS(P_DEBOUNCE_TICKS),
         .P_LONG_TICKS    (P_LONG_TICKS),
         .P_CNT_WIDTH     (P_CNT_WIDTH),
         .P_LONG_EN       (1'b1)
      ) u_chan (
         .clk  (I_CLK_100MHZ),
         .rst  (I_RST),
         .ce   (I_CE_10KHZ),
         .raw  (I_BTN[i]),
         .level(O_BTN_LEVEL[i]),
         .press(O_BTN_PRESS[i]),
         .rel  (O_BTN_RELEASE[i]),
         .lng  (O_BTN_LONG[i])
      );
   end

   for (genvar i = 0; i < P_SW_NUM; i++) begin : g_sw
      io_user_buttons_debounce_channel #(
         .P_DEBOUNCE_TICKS(P_DEBOUNCE_TICKS),
         .P_LONG_TICKS    (P_LONG_TICKS),
         .P_CNT_WIDTH     (P_CNT_WIDTH),
         .P_LONG_EN       (1'b0)
      ) u_chan (
         .clk  (I_CLK_100MHZ),
         .rst  (I_RST),
         .ce   (I_CE_10KHZ),
         .raw  (I_SW[i]),
         .level(O_SW_LEVEL[i]),
         .press(sw_press_unused[i]),
         .rel  (sw_rel_unused[i]),
         .lng  (sw_long_unused[i])
      );
   end

endmodule

// File: tb/tb_io_user_buttons.sv
// Directed bench for io_user_buttons with short debounce (4) and long-press (10) ticks.
module tb_io_user_buttons;

   logic       clk = 1'b0;
   logic       rst;
   logic       ce;
   logic [3:0] btn;
   logic [3:0] sw;
   logic [3:0] btn_level, btn_press, btn_release, btn_long, sw_level;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   io_user_buttons #(
      .P_BTN_NUM       (4),
      .P_SW_NUM        (4),
      .P_DEBOUNCE_TICKS(4),
      .P_LONG_TICKS    (10)
   ) dut (
      .I_CLK_100MHZ (clk),
      .I_RST        (rst),
      .I_CE_10KHZ   (ce),
      .I_BTN        (btn),
      .I_SW         (sw),
      .O_BTN_LEVEL  (btn_level),
      .O_BTN_PRESS  (btn_press),
      .O_BTN_RELEASE(btn_release),
      .O_BTN_LONG   (btn_long),
      .O_SW_LEVEL   (sw_level)
   );

   // One clock, then compare {level,press,release,long,sw} 1 ns after the edge.
   task automatic step(input string tag, input logic [3:0] e_lvl, input logic [3:0] e_press,
                       input logic [3:0] e_rel, input logic [3:0] e_long, input logic [3:0] e_sw);
      logic [19:0] obs, exp;
      @(posedge clk);
      #1;
      obs = {btn_level, btn_press, btn_release, btn_long, sw_level};
      exp = {e_lvl, e_press, e_rel, e_long, e_sw};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed lvl/prs/rel/lng/sw=%05h expected=%05h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      ce  = 1'b1;
      btn = 4'h0;
      sw  = 4'h0;

      // Reset state
      step("reset_a", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      step("reset_b", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      rst = 1'b0;

      // Clean press and release on button 0
      btn[0] = 1'b1;
      for (int k = 1; k <= 7; k++)
         step($sformatf("press0_k%0d", k), (k >= 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0,
              4'h0, 4'h0, 4'h0);
      btn[0] = 1'b0;
      for (int k = 1; k <= 7; k++)
         step($sformatf("rel0_k%0d", k), (k < 6) ? 4'h1 : 4'h0, 4'h0,
              (k == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0);

      // Bounce on button 1: 1,0,1,0 then steady 1
      for (int k = 1; k <= 12; k++) begin
         btn[1] = (k >= 5) ? 1'b1 : ((k % 2) == 1);
         step($sformatf("bounce1_k%0d", k), (k >= 10) ? 4'h2 : 4'h0, (k == 10) ? 4'h2 : 4'h0,
              4'h0, 4'h0, 4'h0);
      end
      btn[1] = 1'b0;
      for (int k = 1; k <= 7; k++)
         step($sformatf("rel1_k%0d", k), (k < 6) ? 4'h2 : 4'h0, 4'h0,
              (k == 6) ? 4'h2 : 4'h0, 4'h0, 4'h0);

      // Long press on button 2: held 30 clocks
      for (int k = 1; k <= 45; k++) begin
         btn[2] = (k <= 30);
         step($sformatf("long2_k%0d", k), (k >= 6 && k < 36) ? 4'h4 : 4'h0,
              (k == 6) ? 4'h4 : 4'h0, (k == 36) ? 4'h4 : 4'h0,
              (k == 16) ? 4'h4 : 4'h0, 4'h0);
      end

      // Switch 3 with CE every 5th clock: 2-tick glitch rejected
      for (int k = 1; k <= 20; k++) begin
         ce    = ((k % 5) == 0);
         sw[3] = (k <= 10);
         step($sformatf("swglitch_k%0d", k), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      end
      // 4-tick change accepted on the 4th CE seeing the new level
      sw[3] = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         ce = ((k % 5) == 0);
         step($sformatf("swchange_k%0d", k), 4'h0, 4'h0, 4'h0, 4'h0,
              (k >= 20) ? 4'h8 : 4'h0);
      end
      ce    = 1'b1;
      sw[3] = 1'b0;
      for (int k = 1; k <= 7; k++)
         step($sformatf("swoff_k%0d", k), 4'h0, 4'h0, 4'h0, 4'h0, (k < 6) ? 4'h8 : 4'h0);

      // Reset mid-count on button 0
      btn[0] = 1'b1;
      for (int k = 1; k <= 3; k++)
         step($sformatf("rstmid_pre_k%0d", k), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      rst = 1'b1;
      step("rstmid", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      rst = 1'b0;
      for (int k = 1; k <= 8; k++)
         step($sformatf("rstmid_post_k%0d", k), (k >= 6) ? 4'h1 : 4'h0,
              (k == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0, 4'h0);

      // Reset while held: level forced low with no release, then re-pressed
      rst = 1'b1;
      step("rsthold", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      rst = 1'b0;
      for (int k = 1; k <= 7; k++)
         step($sformatf("rsthold_post_k%0d", k), (k >= 6) ? 4'h1 : 4'h0,
              (k == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0, 4'h0);
      btn[0] = 1'b0;
      for (int k = 1; k <= 7; k++)
         step($sformatf("rsthold_rel_k%0d", k), (k < 6) ? 4'h1 : 4'h0, 4'h0,
              (k == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0);

      // All four buttons pressed and released together
      btn = 4'hF;
      for (int k = 1; k <= 7; k++)
         step($sformatf("all_press_k%0d", k), (k >= 6) ? 4'hF : 4'h0,
              (k == 6) ? 4'hF : 4'h0, 4'h0, 4'h0, 4'h0);
      btn = 4'h0;
      for (int k = 1; k <= 7; k++)
         step($sformatf("all_rel_k%0d", k), (k < 6) ? 4'hF : 4'h0, 4'h0,
              (k == 6) ? 4'hF : 4'h0, 4'h0, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
